// File: rtl/hline_hit_detect_pkg.sv
// Shared types and widths for the line/cube collision block.
// Imported by the overlap counter and the round-state top.
package hline_hit_detect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam int OVL_W = 10;
    localparam int FRM_W = 8;

endpackage

// File: rtl/hline_hit_detect_overlap_counter.sv
// Saturating per-frame count of cube/line overlap pixels.
// The verdict uses the count before the frame_tick clear.
module overlap_counter
    import hline_hit_detect_pkg::*;
#(
    parameter int MIN_OVERLAP = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic px,
    output logic collide
);

    localparam logic [OVL_W-1:0] SAT   = '1;
    localparam logic [OVL_W-1:0] MIN_V = OVL_W'(MIN_OVERLAP);

    logic [OVL_W-1:0] cnt;

    // Count overlaps; a pixel on the tick cycle belongs to the next frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (frame_tick)
            cnt <= {{(OVL_W-1){1'b0}}, px};
        else if (px && cnt != SAT)
            cnt <= cnt + 1'b1;
    end

    assign collide = (cnt >= MIN_V);

endmodule

// File: rtl/hline_hit_detect.sv
// Round state for the line game: lives, post-hit flash, game over.
// Decides once per frame whether the cube touched a line.
module hline_hit_detect
    import hline_hit_detect_pkg::*;
#(
    parameter int MIN_OVERLAP  = 4,
    parameter int FLASH_FRAMES = 120,
    parameter int LIVES        = 3,
    parameter int BLINK_LOG2   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       active,
    input  logic       line_px,
    input  logic       cube_px,
    input  logic       start,
    output logic       run,
    output logic       flash,
    output logic       load_counter,
    output logic       hit,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam logic [1:0]       LIVES_V    = 2'(LIVES);
    localparam logic [FRM_W-1:0] FLASH_LAST = FRM_W'(FLASH_FRAMES - 1);

    state_t           state_q, state_d;
    logic [FRM_W-1:0] frm_q, frm_d;
    logic [1:0]       lives_q, lives_d;
    logic             load_d, hit_d;
    logic             run_d, flash_d, over_d;
    logic             collide;

    overlap_counter #(
        .MIN_OVERLAP(MIN_OVERLAP)
    ) u_ovl (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .px        (active & line_px & cube_px),
        .collide   (collide)
    );

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            frm_q        <= '0;
            lives_q      <= '0;
            run          <= 1'b0;
            flash        <= 1'b1;
            load_counter <= 1'b0;
            hit          <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frm_q        <= frm_d;
            lives_q      <= lives_d;
            run          <= run_d;
            flash        <= flash_d;
            load_counter <= load_d;
            hit          <= hit_d;
            game_over    <= over_d;
        end
    end

    // Next state, lives, flash frame count and event pulses
    always_comb begin
        state_d = state_q;
        frm_d   = frm_q;
        lives_d = lives_q;
        load_d  = 1'b0;
        hit_d   = 1'b0;
        unique case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d = PLAY;
                    lives_d = LIVES_V;
                    load_d  = 1'b1;
                end
            end
            PLAY: begin
                if (frame_tick && collide) begin
                    state_d = HIT;
                    hit_d   = 1'b1;
                    lives_d = lives_q - 1'b1;
                    frm_d   = '0;
                end
            end
            HIT: begin
                if (frame_tick) begin
                    frm_d = frm_q + 1'b1;
                    if (frm_q == FLASH_LAST) begin
                        if (lives_q != 2'd0) begin
                            state_d = PLAY;
                            load_d  = 1'b1;
                        end else begin
                            state_d = OVER;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line controls as seen from the upcoming state
    always_comb begin
        run_d   = (state_d == PLAY);
        over_d  = (state_d == OVER);
        flash_d = 1'b1;
        unique case (state_d)
            HIT:     flash_d = frm_d[BLINK_LOG2];
            OVER:    flash_d = 1'b0;
            default: flash_d = 1'b1;
        endcase
    end

    assign lives = lives_q;

endmodule

// File: tb/tb_hline_hit_detect.sv
// Bench for hline_hit_detect: scenario tasks plus a hit scoreboard.
// Expected hits are queued when the deciding tick is driven.
module tb_hline_hit_detect;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       active = 1'b0;
    logic       line_px = 1'b0;
    logic       cube_px = 1'b0;
    logic       start = 1'b0;
    logic       run, flash, load_counter, hit, game_over;
    logic [1:0] lives;

    int n_assert = 0;
    int n_fail = 0;
    logic [1:0] exp_q[$];
    logic [1:0] prev_lives = 2'd0;

    hline_hit_detect dut (
        .clk         (clk),
        .reset       (rst_n),
        .frame_tick  (frame_tick),
        .active      (active),
        .line_px     (line_px),
        .cube_px     (cube_px),
        .start       (start),
        .run         (run),
        .flash       (flash),
        .load_counter(load_counter),
        .hit         (hit),
        .lives       (lives),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    // Scoreboard: every hit pulse must match a queued expectation
    always @(negedge clk) begin
        if (rst_n && hit) begin
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_hit: hit=1 lives=%0d, no hit expected",
                         lives);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (lives !== e) begin
                    n_fail++;
                    $display("FAIL hit_lives: got %0d expected %0d", lives, e);
                end
            end
            n_assert++;
            if (prev_lives == 2'd0) begin
                n_fail++;
                $display("FAIL lives_underflow: hit with lives=0 before, now %0d",
                         lives);
            end
        end
        prev_lives = lives;
    end

    task automatic drive(input bit a, input bit l, input bit c,
                         input bit s, input bit t);
        active = a;
        line_px = l;
        cube_px = c;
        start = s;
        frame_tick = t;
        @(posedge clk);
        @(negedge clk);
        active = 1'b0;
        line_px = 1'b0;
        cube_px = 1'b0;
        start = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic frame(input int n, input bit tick_px);
        for (int i = 0; i < n; i++) drive(1, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        drive(1, tick_px, tick_px, 0, 1);
    endtask

    task automatic flash_ticks(input int n);
        for (int i = 0; i < n; i++) frame(0, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        n_assert++;
        if ({run, flash, load_counter, hit, lives, game_over} !== 7'b0100000) begin
            n_fail++;
            $display("FAIL %s: run=%b flash=%b load=%b hit=%b lives=%0d go=%b, required 0 1 0 0 0 0",
                     tag, run, flash, load_counter, hit, lives, game_over);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset_values");
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1);
        chk_reset_vals("idle_after_tick");
    endtask

    task automatic test_start();
        drive(0, 0, 0, 1, 0);
        n_assert++;
        if ({load_counter, run, lives, flash, game_over} !== 6'b111110) begin
            n_fail++;
            $display("FAIL start: load=%b run=%b lives=%0d flash=%b go=%b, required 1 1 3 1 0",
                     load_counter, run, lives, flash, game_over);
        end
        drive(0, 0, 0, 0, 0);
        n_assert++;
        if (load_counter !== 1'b0 || run !== 1'b1) begin
            n_fail++;
            $display("FAIL load_one_cycle: load=%b run=%b, required 0 1",
                     load_counter, run);
        end
    endtask

    task automatic test_threshold();
        frame(3, 0);
        n_assert++;
        if (hit !== 1'b0 || run !== 1'b1) begin
            n_fail++;
            $display("FAIL three_px: hit=%b run=%b, required 0 1", hit, run);
        end
        exp_q.push_back(2'd2);
        frame(4, 0);
        n_assert++;
        if (hit !== 1'b1 || run !== 1'b0 || lives !== 2'd2) begin
            n_fail++;
            $display("FAIL four_px: hit=%b run=%b lives=%0d, required 1 0 2",
                     hit, run, lives);
        end
        drive(0, 0, 0, 0, 0);
        n_assert++;
        if (hit !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_pulse: hit=%b, required 0", hit);
        end
    endtask

    task automatic test_flash();
        drive(0, 0, 0, 1, 0);
        n_assert++;
        if (run !== 1'b0 || load_counter !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_hit: run=%b load=%b, required 0 0",
                     run, load_counter);
        end
        for (int k = 1; k < 120; k++) begin
            frame((k % 2) ? 5 : 0, 0);
            n_assert++;
            if (flash !== 1'((k >> 3) & 1) || run !== 1'b0 ||
                load_counter !== 1'b0) begin
                n_fail++;
                $display("FAIL flash_tick%0d: flash=%b run=%b load=%b, required %0d 0 0",
                         k, flash, run, load_counter, (k >> 3) & 1);
            end
        end
        frame(0, 0);
        n_assert++;
        if (run !== 1'b1 || load_counter !== 1'b1 || lives !== 2'd2 ||
            flash !== 1'b1) begin
            n_fail++;
            $display("FAIL flash_exit: run=%b load=%b lives=%0d flash=%b, required 1 1 2 1",
                     run, load_counter, lives, flash);
        end
        drive(0, 0, 0, 0, 0);
        n_assert++;
        if (load_counter !== 1'b0) begin
            n_fail++;
            $display("FAIL exit_load_pulse: load=%b, required 0", load_counter);
        end
    endtask

    task automatic test_game_over();
        exp_q.push_back(2'd1);
        frame(4, 0);
        flash_ticks(120);
        n_assert++;
        if (run !== 1'b1 || lives !== 2'd1) begin
            n_fail++;
            $display("FAIL second_life: run=%b lives=%0d, required 1 1",
                     run, lives);
        end
        exp_q.push_back(2'd0);
        frame(4, 0);
        flash_ticks(119);
        n_assert++;
        if (game_over !== 1'b0 || run !== 1'b0) begin
            n_fail++;
            $display("FAIL before_over: go=%b run=%b, required 0 0",
                     game_over, run);
        end
        frame(0, 0);
        n_assert++;
        if (game_over !== 1'b1 || flash !== 1'b0 || lives !== 2'd0 ||
            run !== 1'b0 || load_counter !== 1'b0) begin
            n_fail++;
            $display("FAIL over: go=%b flash=%b lives=%0d run=%b load=%b, required 1 0 0 0 0",
                     game_over, flash, lives, run, load_counter);
        end
        frame(6, 0);
        n_assert++;
        if (game_over !== 1'b1 || hit !== 1'b0) begin
            n_fail++;
            $display("FAIL over_hold: go=%b hit=%b, required 1 0",
                     game_over, hit);
        end
        drive(0, 0, 0, 1, 0);
        n_assert++;
        if (run !== 1'b1 || lives !== 2'd3 || load_counter !== 1'b1 ||
            game_over !== 1'b0 || flash !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: run=%b lives=%0d load=%b go=%b flash=%b, required 1 3 1 0 1",
                     run, lives, load_counter, game_over, flash);
        end
    endtask

    task automatic test_tick_pixel();
        frame(3, 1);
        n_assert++;
        if (hit !== 1'b0 || run !== 1'b1) begin
            n_fail++;
            $display("FAIL tick_px_frame: hit=%b run=%b, required 0 1", hit, run);
        end
        exp_q.push_back(2'd2);
        frame(3, 0);
        n_assert++;
        if (hit !== 1'b1 || lives !== 2'd2) begin
            n_fail++;
            $display("FAIL carry_frame: hit=%b lives=%0d, required 1 2",
                     hit, lives);
        end
    endtask

    task automatic test_reset_in_hit();
        flash_ticks(10);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_reset_hit");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        chk_reset_vals("idle_after_async");
        drive(0, 0, 0, 1, 0);
        n_assert++;
        if (run !== 1'b1 || lives !== 2'd3 || load_counter !== 1'b1) begin
            n_fail++;
            $display("FAIL start_after_reset: run=%b lives=%0d load=%b, required 1 3 1",
                     run, lives, load_counter);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_threshold();
        test_flash();
        test_game_over();
        test_tick_pixel();
        test_reset_in_hit();
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_hits: %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
